// File: rtl/sat_mac_pkg.sv
// Shared definitions for the saturating MAC: mode encoding and W-bit saturation bounds.
// Pure declarations; no timing or flow-control behaviour of its own.
package sat_pkg;

    typedef enum logic {
        MODE_MUL = 1'b0,
        MODE_MAC = 1'b1
    } mode_e;

    function automatic logic signed [63:0] sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/sat_mac_if.sv
// Beat/result bundle for sat_mac: master drives beats and clr_ovfl, slave returns results.
// No handshake back to the master; the slave accepts one beat every cycle.
interface sat_mac_if #(
    parameter int W = 16
);
    logic                in_vld;
    logic signed [W-1:0] coeff;
    logic signed [W-1:0] samp;
    logic                mode;
    logic                first;
    logic                last;
    logic                clr_ovfl;
    logic                out_vld;
    logic signed [W-1:0] result;
    logic                sat_flag;
    logic                ovfl;

    modport master (
        output in_vld, coeff, samp, mode, first, last, clr_ovfl,
        input  out_vld, result, sat_flag, ovfl
    );

    modport slave (
        input  in_vld, coeff, samp, mode, first, last, clr_ovfl,
        output out_vld, result, sat_flag, ovfl
    );

endinterface

// File: rtl/sat_mac_clip.sv
// Combinational two's-complement narrowing from IN_W to OUT_W bits with clip-to-rail and flag.
// Zero latency, no flow control; IN_W must be >= OUT_W.
module sat_clip
    import sat_pkg::*;
#(
    parameter int IN_W  = 17,
    parameter int OUT_W = 16
) (
    input  logic [IN_W-1:0]  i_val,
    output logic [OUT_W-1:0] o_val,
    output logic             o_sat
);

    localparam logic signed [63:0] MAX64 = sat_max(OUT_W);
    localparam logic signed [63:0] MIN64 = sat_min(OUT_W);
    localparam logic [OUT_W-1:0]   MAXV  = MAX64[OUT_W-1:0];
    localparam logic [OUT_W-1:0]   MINV  = MIN64[OUT_W-1:0];

    // The value fits only if every bit from the OUT_W sign position upward is a sign copy.
    logic [IN_W-OUT_W:0] w_top;
    assign w_top = i_val[IN_W-1:OUT_W-1];

    assign o_sat = !((&w_top) || !(|w_top));
    assign o_val = o_sat ? (i_val[IN_W-1] ? MINV : MAXV) : i_val[OUT_W-1:0];

endmodule

// File: rtl/sat_mac.sv
// Signed fractional multiply(-accumulate) with saturation and sticky overflow; 2-cycle latency.
// One beat per cycle, no backpressure; bubbles leave accumulator and flags untouched.
module sat_mac
    import sat_pkg::*;
#(
    parameter int W    = 16,
    parameter int FRAC = 14
) (
    input  logic     clk,
    input  logic     rst,
    sat_mac_if.slave bus
);

    localparam int PW = 2 * W;
    localparam int SW = 2 * W - FRAC;

    logic signed [PW-1:0] w_p;
    assign w_p = PW'(bus.coeff) * PW'(bus.samp);

    logic signed [PW-1:0] r_p;
    mode_e                r_mode;
    logic                 r_first;
    logic                 r_last;
    logic                 r_vld;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p     <= '0;
            r_mode  <= MODE_MUL;
            r_first <= 1'b0;
            r_last  <= 1'b0;
            r_vld   <= 1'b0;
        end else begin
            r_vld <= bus.in_vld;
            if (bus.in_vld) begin
                r_p     <= w_p;
                r_mode  <= mode_e'(bus.mode);
                r_first <= bus.first;
                r_last  <= bus.last;
            end
        end
    end

    // Arithmetic shift floors; the truncating cast keeps only the bits the clip inspects.
    logic [SW-1:0] w_s;
    logic [W-1:0]  w_prod;
    logic          w_prod_sat;
    assign w_s = SW'(r_p >>> FRAC);

    sat_clip #(.IN_W(SW), .OUT_W(W)) u_prod_clip (
        .i_val (w_s),
        .o_val (w_prod),
        .o_sat (w_prod_sat)
    );

    logic [W-1:0] r_acc;
    logic         r_trk;
    logic [W-1:0] w_base;
    logic [W:0]   w_sum;
    logic [W-1:0] w_acc_nxt;
    logic         w_acc_sat;
    logic         w_trk_nxt;

    assign w_base = r_first ? '0 : r_acc;
    assign w_sum  = {w_base[W-1], w_base} + {w_prod[W-1], w_prod};

    sat_clip #(.IN_W(W + 1), .OUT_W(W)) u_acc_clip (
        .i_val (w_sum),
        .o_val (w_acc_nxt),
        .o_sat (w_acc_sat)
    );

    assign w_trk_nxt = (r_first ? 1'b0 : r_trk) | w_prod_sat | w_acc_sat;

    logic         w_is_mul;
    logic         w_issue;
    logic         w_issue_sat;
    logic [W-1:0] w_issue_val;

    assign w_is_mul    = (r_mode == MODE_MUL);
    assign w_issue     = r_vld && (w_is_mul || r_last);
    assign w_issue_sat = w_is_mul ? w_prod_sat : w_trk_nxt;
    assign w_issue_val = w_is_mul ? w_prod : w_acc_nxt;

    logic         r_out_vld;
    logic [W-1:0] r_result;
    logic         r_sat;
    logic         r_ovfl;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc     <= '0;
            r_trk     <= 1'b0;
            r_out_vld <= 1'b0;
            r_result  <= '0;
            r_sat     <= 1'b0;
            r_ovfl    <= 1'b0;
        end else begin
            r_out_vld <= w_issue;
            if (w_issue) begin
                r_result <= w_issue_val;
                r_sat    <= w_issue_sat;
            end
            if (r_vld && !w_is_mul) begin
                r_acc <= w_acc_nxt;
                r_trk <= w_trk_nxt;
            end
            // A saturating issue on the same edge as a clear keeps the flag set.
            if (w_issue && w_issue_sat) begin
                r_ovfl <= 1'b1;
            end else if (bus.clr_ovfl) begin
                r_ovfl <= 1'b0;
            end
        end
    end

    assign bus.out_vld  = r_out_vld;
    assign bus.result   = r_result;
    assign bus.sat_flag = r_sat;
    assign bus.ovfl     = r_ovfl;

endmodule
